// File: rtl/inert_intf.sv
// inert_intf: SPI front end for a 6-axis inertial sensor.
// After reset it waits for the power-up timer to expire. It then writes the
// four configuration registers. After that it reads one full sample set
// (pitch/roll/yaw rates, ax, ay) each time the sensor raises INT.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   INT               sensor data-ready (asynchronous, synchronized here)
//   done, rd_data     SPI master completion pulse and returned word
//   wrt, cmd          SPI transaction start pulse and command word
//   vld               one-cycle pulse when a new sample set is on the outputs
//   ptch_rt..ay       signed raw sensor words
module inert_intf #(
  parameter int PWR_TMR_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] roll_rt,
  output logic [15:0] yaw_rt,
  output logic [15:0] ax,
  output logic [15:0] ay
);

  typedef enum logic [2:0] {PWR_WAIT, INIT, WAIT_INT, READ, UPDATE} state_t;

  state_t               state, state_nxt;
  logic [PWR_TMR_W-1:0] tmr;
  logic [3:0]           cnt;
  logic [3:0]           cnt_nxt;
  logic                 busy;     // one SPI transaction outstanding
  logic                 ack;      // done that belongs to our transaction
  logic [7:0]           lo_byte;
  logic                 int_ff1, int_s;

  function automatic logic [15:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 16'h0D02;
      2'd1:    init_cmd = 16'h1062;
      2'd2:    init_cmd = 16'h1162;
      default: init_cmd = 16'h1460;
    endcase
  endfunction

  assign ack     = done & busy;
  assign cnt_nxt = cnt + 4'd1;
  assign vld     = (state == UPDATE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      int_ff1 <= 1'b0;
      int_s   <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_s   <= int_ff1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= PWR_WAIT;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      PWR_WAIT: if (&tmr)             state_nxt = INIT;
      INIT:     if (ack && cnt == 4'd3) state_nxt = WAIT_INT;
      WAIT_INT: if (int_s)            state_nxt = READ;
      READ:     if (ack && cnt == 4'd9) state_nxt = UPDATE;
      UPDATE:                         state_nxt = WAIT_INT;
      default:                        state_nxt = PWR_WAIT;
    endcase
  end

  // Datapath: wrt is registered, so a command issued on an edge where done is
  // seen appears in the cycle after done. cmd holds until the next issue.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tmr     <= '0;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      wrt     <= 1'b0;
      cmd     <= 16'h0000;
      lo_byte <= 8'h00;
      ptch_rt <= 16'h0000;
      roll_rt <= 16'h0000;
      yaw_rt  <= 16'h0000;
      ax      <= 16'h0000;
      ay      <= 16'h0000;
    end else begin
      wrt <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (&tmr) begin
            wrt  <= 1'b1;
            cmd  <= init_cmd(2'd0);
            busy <= 1'b1;
            cnt  <= 4'd0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        INIT: begin
          if (ack) begin
            if (cnt == 4'd3) begin
              busy <= 1'b0;
              cnt  <= 4'd0;
            end else begin
              cnt <= cnt_nxt;
              wrt <= 1'b1;
              cmd <= init_cmd(cnt_nxt[1:0]);
            end
          end
        end
        WAIT_INT: begin
          if (int_s) begin
            cnt  <= 4'd0;
            wrt  <= 1'b1;
            cmd  <= 16'hA200;
            busy <= 1'b1;
          end
        end
        READ: begin
          if (ack) begin
            // Even reads are low bytes; odd reads complete a word.
            if (!cnt[0]) lo_byte <= rd_data[7:0];
            else begin
              case (cnt[3:1])
                3'd0:    ptch_rt <= {rd_data[7:0], lo_byte};
                3'd1:    roll_rt <= {rd_data[7:0], lo_byte};
                3'd2:    yaw_rt  <= {rd_data[7:0], lo_byte};
                3'd3:    ax      <= {rd_data[7:0], lo_byte};
                default: ay      <= {rd_data[7:0], lo_byte};
              endcase
            end
            if (cnt == 4'd9) begin
              busy <= 1'b0;
            end else begin
              cnt <= cnt_nxt;
              wrt <= 1'b1;
              cmd <= {8'hA2 + {4'h0, cnt_nxt}, 8'h00};
            end
          end
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_inert_intf.sv
module tb_inert_intf;
  logic        clk = 1'b0;
  logic        rst_n, INT, mdone, spur;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt, vld;
  logic [15:0] cmd, ptch_rt, roll_rt, yaw_rt, ax, ay;

  assign done = mdone | spur;
  always #5 clk = ~clk;

  inert_intf #(.PWR_TMR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .ptch_rt(ptch_rt), .roll_rt(roll_rt),
    .yaw_rt(yaw_rt), .ax(ax), .ay(ay)
  );

  typedef struct {
    logic [7:0]  b [10];
    logic [15:0] exp [5];
  } run_t;

  int n_chk = 0, n_fail = 0;
  int cyc, wrt_cnt = 0, vld_cnt = 0, done_cnt = 0, dbl = 0, stab_err = 0;
  int first_wrt = -1, vld_cyc = 0, done_cyc = 0;
  int rst_gen = 0, mgen = 0;
  logic        wrt_prev = 1'b0, mbusy = 1'b0;
  logic [15:0] cur_cmd = 16'h0;
  logic [15:0] cmd_log [64];
  logic [7:0]  resp [10];
  logic [15:0] init_tab [4];
  run_t        runs [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic wait_for(input string nm, ref int ctr, input int target, input int lim);
    int k = 0;
    while (ctr < target && k < lim) begin
      @(posedge clk);
      k++;
    end
    if (ctr < target) chk({nm, " timeout"}, ctr, target);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Monitor, sampled on the falling edge.
  always @(negedge clk)
    if (rst_n) begin
      if (wrt) begin
        if (first_wrt < 0) first_wrt = cyc;
        if (wrt_cnt < 64) cmd_log[wrt_cnt] = cmd;
        wrt_cnt++;
        if (wrt_prev) dbl++;
      end
      wrt_prev = wrt;
      if (vld) begin vld_cnt++; vld_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (mbusy && mgen == rst_gen && cmd !== cur_cmd) stab_err++;
    end

  // SPI master model: done 5 cycles after wrt, read data chosen by address.
  initial begin
    mdone = 1'b0;
    rd_data = 16'h0;
    forever begin
      @(posedge clk); #1;
      while (wrt) begin
        cur_cmd = cmd; mgen = rst_gen; mbusy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (cur_cmd[15:8] >= 8'hA2 && cur_cmd[15:8] <= 8'hAB)
          rd_data = {8'h5A, resp[cur_cmd[15:8] - 8'hA2]};
        else
          rd_data = 16'hFFFF;
        mdone = 1'b1;
        @(posedge clk); #1;
        mdone = 1'b0; mbusy = 1'b0;
      end
    end
  end

  initial begin
    int base, vb, bd;
    init_tab = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};
    runs[0].b   = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hFF, 8'h7F, 8'h00, 8'h80};
    runs[0].exp = '{16'h1234, 16'hABCD, 16'h0001, 16'h7FFF, 16'h8000};
    runs[1].b   = '{8'h11, 8'h22, 8'h80, 8'h00, 8'hFE, 8'hFF, 8'h5A, 8'hA5, 8'h3C, 8'hC3};
    runs[1].exp = '{16'h2211, 16'h0080, 16'hFFFE, 16'hA55A, 16'hC33C};
    for (int i = 0; i < 10; i++) resp[i] = 8'h00;

    rst_n = 1'b0; INT = 1'b0; spur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst wrt", wrt, 0);   chk("rst cmd", cmd, 0);   chk("rst vld", vld, 0);
    chk("rst ptch", ptch_rt, 0); chk("rst roll", roll_rt, 0); chk("rst yaw", yaw_rt, 0);
    chk("rst ax", ax, 0);     chk("rst ay", ay, 0);
    @(negedge clk); rst_n = 1'b1;

    // INIT, with an INT pulse that must be ignored
    wait_for("first wrt", wrt_cnt, 1, 100);
    INT = 1'b1; repeat (4) @(posedge clk); INT = 1'b0;
    wait_for("init wrts", wrt_cnt, 4, 200);
    chk("first wrt cycle", first_wrt, 16);
    repeat (40) @(posedge clk);
    chk("init wrt count", wrt_cnt, 4);
    chk("init no vld", vld_cnt, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("init cmd %0d", i), cmd_log[i], init_tab[i]);

    // spurious done while idle
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    repeat (10) @(posedge clk);
    chk("spur no wrt", wrt_cnt, 4);
    chk("spur no vld", vld_cnt, 0);

    // read runs; INT held through the first reads then dropped
    for (int r = 0; r < 2; r++) begin
      resp = runs[r].b;
      base = wrt_cnt; vb = vld_cnt;
      INT = 1'b1;
      wait_for("read start", wrt_cnt, base + 3, 300);
      INT = 1'b0;
      wait_for("vld", vld_cnt, vb + 1, 500);
      chk($sformatf("r%0d vld after done", r), vld_cyc - done_cyc, 1);
      repeat (30) @(posedge clk);
      chk($sformatf("r%0d vld count", r), vld_cnt, vb + 1);
      chk($sformatf("r%0d wrt count", r), wrt_cnt, base + 10);
      chk($sformatf("r%0d ptch", r), ptch_rt, runs[r].exp[0]);
      chk($sformatf("r%0d roll", r), roll_rt, runs[r].exp[1]);
      chk($sformatf("r%0d yaw", r), yaw_rt, runs[r].exp[2]);
      chk($sformatf("r%0d ax", r), ax, runs[r].exp[3]);
      chk($sformatf("r%0d ay", r), ay, runs[r].exp[4]);
      for (int i = 0; i < 10; i++)
        chk($sformatf("r%0d cmd %0d", r, i), cmd_log[base + i], {8'hA2 + 8'(i), 8'h00});
    end

    // reset after the 5th read done
    resp = runs[0].b;
    bd = done_cnt;
    INT = 1'b1;
    wait_for("5th done", done_cnt, bd + 5, 400);
    @(posedge clk); #2;
    rst_n = 1'b0; rst_gen++;
    #1;
    chk("mid rst ptch", ptch_rt, 0); chk("mid rst roll", roll_rt, 0);
    chk("mid rst cmd", cmd, 0);      chk("mid rst wrt", wrt, 0);
    first_wrt = -1; base = wrt_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    wait_for("post rst wrts", wrt_cnt, base + 5, 400);
    chk("post rst first wrt", first_wrt, 16);
    for (int i = 0; i < 4; i++)
      chk($sformatf("post rst init %0d", i), cmd_log[base + i], init_tab[i]);
    chk("post rst first read", cmd_log[base + 4], 16'hA200);
    INT = 1'b0;
    vb = vld_cnt;
    wait_for("post rst vld", vld_cnt, vb + 1, 500);
    repeat (5) @(posedge clk);
    chk("post rst ptch", ptch_rt, 16'h1234);
    chk("post rst ay", ay, 16'h8000);

    chk("wrt single cycle", dbl, 0);
    chk("cmd stable", stab_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1);
  end
endmodule
